muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations issued from the EX stage. It holds the pipeline with a stall while a product or an iterative radix-2 quotient/remainder is formed. It then presents a registered 32-bit result for exactly one cycle, during which the pipeline advances. It sits beside the ALU and is driven by the ID/EX control bits (M-extension op valid plus funct3) and the forwarded EX operands.

---
 rtl/muldiv_sequencer_if.sv | 38 +++
 rtl/muldiv_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake/data bundle between the EX stage and the RV32M multiply/divide
// sequencer.
//   start_i     : EX holds a valid M-extension op (held until done_o)
//   op_i        : funct3 of the M op
//   operand_a_i : forwarded rs1 value
//   operand_b_i : forwarded rs2 value
//   flush_i     : abort the current op, no result
//   stall_o     : combinational pipeline hold
//   busy_o      : sequencer is not idle
//   done_o      : registered one-cycle completion pulse
//   result_o    : registered result, held until the next completion
// The master modport is the pipeline side, the slave modport the sequencer.
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, operand_a_i, operand_b_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, operand_a_i, operand_b_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle RV32M multiply/divide unit beside the EX-stage ALU. Stalls the
// pipeline while a single-cycle 64-bit product or a 32-step restoring
// radix-2 division is formed, then presents a registered result for exactly
// one cycle (DONE) in which the pipeline advances.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_sequencer_if.slave (start/op/operands/flush in,
//          stall/busy/done/result out)
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? f_neg(v) : v;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;       // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   r_b;       // multiplier, or divisor magnitude
    logic [XLEN-1:0]   r_rem;     // partial remainder
    logic [4:0]        r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    // Decode of the op presented in IDLE
    logic              w_accept;
    logic              w_is_div;
    logic              w_div_signed;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special_res;

    assign w_accept     = bus.start_i & ~bus.flush_i;
    assign w_is_div     = bus.op_i[2];
    assign w_div_signed = ~bus.op_i[0];
    assign w_div_zero   = (bus.operand_b_i == '0);
    assign w_div_ovf    = w_div_signed & (bus.operand_a_i == MIN_NEG)
                        & (bus.operand_b_i == ALL_ONE);

    // Divide by zero: q = all ones, r = dividend. Overflow: q = MIN_NEG, r = 0.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.op_i[1] ? bus.operand_a_i : ALL_ONE;
        end else begin
            w_special_res = bus.op_i[1] ? '0 : MIN_NEG;
        end
    end

    // Product: operands widened by one bit so one signed multiply covers
    // signed, mixed and unsigned forms; the 64-bit truncation is exact.
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic signed [XLEN:0] w_a_ext;
    logic signed [XLEN:0] w_b_ext;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]    w_mul_res;

    assign w_a_sgn = (r_op == 3'b001) | (r_op == 3'b010);
    assign w_b_sgn = (r_op == 3'b001);
    assign w_a_ext = {w_a_sgn & r_a[XLEN-1], r_a};
    assign w_b_ext = {w_b_sgn & r_b[XLEN-1], r_b};
    assign w_prod  = (2*XLEN)'(w_a_ext) * (2*XLEN)'(w_b_ext);

    always_comb begin
        case (r_op)
            3'b000:  w_mul_res = w_prod[XLEN-1:0];
            default: w_mul_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // One restoring step: bring in the next dividend bit, trial-subtract,
    // keep the difference when it does not borrow.
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_div_res;

    assign w_shift   = {r_rem, r_a[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_a[XLEN-2:0], w_qbit};
    assign w_div_res = r_op[1] ? (r_neg_r ? f_neg(w_rem_nxt) : w_rem_nxt)
                               : (r_neg_q ? f_neg(w_quo_nxt) : w_quo_nxt);

    // Next state and result load
    logic              w_res_load;
    logic [XLEN-1:0]   w_res_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_res_load  = 1'b0;
        w_res_nxt   = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div) begin
                        w_state_nxt = S_MUL;
                    end else if (w_div_zero || w_div_ovf) begin
                        w_state_nxt = S_DONE;
                        w_res_load  = 1'b1;
                        w_res_nxt   = w_special_res;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                w_state_nxt = S_DONE;
                w_res_load  = 1'b1;
                w_res_nxt   = w_mul_res;
            end
            S_DIV: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_DONE;
                    w_res_load  = 1'b1;
                    w_res_nxt   = w_div_res;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Flush wins over everything, including a start in the same cycle
        if (bus.flush_i) begin
            w_state_nxt = S_IDLE;
            w_res_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == S_DONE);
            if (w_res_load) begin
                r_result <= w_res_nxt;
            end
            if (r_state == S_IDLE && w_accept) begin
                r_op    <= bus.op_i;
                r_rem   <= '0;
                // Signed division works on magnitudes; signs are reapplied at the end
                if (w_is_div && w_div_signed) begin
                    r_a <= f_abs(bus.operand_a_i);
                    r_b <= f_abs(bus.operand_b_i);
                end else begin
                    r_a <= bus.operand_a_i;
                    r_b <= bus.operand_b_i;
                end
                r_neg_q <= w_is_div & w_div_signed
                         & (bus.operand_a_i[XLEN-1] ^ bus.operand_b_i[XLEN-1]);
                r_neg_r <= w_is_div & w_div_signed & bus.operand_a_i[XLEN-1];
                if (w_is_div) begin
                    r_cnt <= 5'd31;
                end
            end else if (r_state == S_DIV) begin
                r_a   <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt != 5'd0) begin
                    r_cnt <= r_cnt - 5'd1;
                end
            end
        end
    end

    assign bus.stall_o  = bus.start_i & ~bus.flush_i & (r_state != S_DONE);
    assign bus.busy_o   = (r_state != S_IDLE);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus ();
    muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
            3'd2: begin sp = 64'(sa) * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        bus.start_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
    endtask

    // Walks cycles from the sampling cycle until done_o, checking stall_o on
    // every cycle and latency/result at completion. Leaves start_i untouched.
    task automatic collect(input string tag);
        int cyc = 0;
        bit got = 1'b0;
        int l;
        l = lat_q[0];
        while (!got && cyc <= 40) begin
            #1;
            chk({tag, "_stall"}, 32'(bus.stall_o), (cyc < l) ? 32'd1 : 32'd0);
            if (bus.done_o) begin
                got = 1'b1;
                chk({tag, "_latency"}, 32'(cyc), 32'(l));
                chk({tag, "_result"}, bus.result_o, exp_q.pop_front());
                void'(lat_q.pop_front());
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'(got), 32'd1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
        drive(op, a, b, exp, lat);
        collect(tag);
        bus.start_i = 1'b0;
        step();
        chk({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_i        = 3'd0;
        bus.operand_a_i = 32'd0;
        bus.operand_b_i = 32'd0;
        bus.flush_i     = 1'b0;
        #2;
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_stall0", 32'(bus.stall_o), 32'd0);
        bus.start_i = 1'b1;
        #1;
        chk("rst_stall1", 32'(bus.stall_o), 32'd1);
        bus.start_i = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Multiplies of all-ones operands
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, "mul");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, "mulh");
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");

        // Flush together with start in IDLE: nothing starts
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'b000;
        #1;
        chk("flush_idle_stall", 32'(bus.stall_o), 32'd0);
        step();
        chk("flush_idle_busy", 32'(bus.busy_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        step();

        // Flush at cycle 10 of a division
        bus.start_i     = 1'b1;
        bus.op_i        = 3'b100;
        bus.operand_a_i = 32'hFFFF_FFF9;
        bus.operand_b_i = 32'd2;
        for (int i = 0; i < 10; i++) step();
        chk("flush_div_busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        step();
        chk("flush_div_busy_after", 32'(bus.busy_o), 32'd0);
        chk("flush_div_done", 32'(bus.done_o), 32'd0);
        chk("flush_div_result", bus.result_o, 32'hFFFF_FFFF);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_done", 32'(bus.done_o), 32'd0);
        end

        // Division of -7 by 2
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, "divu");
        run(3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, "remu");

        // Divide by zero and signed overflow
        run(3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "div0");
        run(3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "divu0");
        run(3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem0");
        run(3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "remu0");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

        // Reset at cycle 20 of a division
        run(3'b101, 32'd1000, 32'd10, 32'd100, 33, "divu_pre_rst");
        bus.start_i     = 1'b1;
        bus.op_i        = 3'b101;
        bus.operand_a_i = 32'd1000;
        bus.operand_b_i = 32'd3;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        #1;
        chk("midrst_done", 32'(bus.done_o), 32'd0);
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_result", bus.result_o, 32'd0);
        chk("midrst_stall_start", 32'(bus.stall_o), 32'd1);
        bus.start_i = 1'b0;
        #1;
        chk("midrst_stall_nostart", 32'(bus.stall_o), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("postrst_done", 32'(bus.done_o), 32'd0);

        // Back-to-back DIVU 100/7 then MUL 6*7
        drive(3'b101, 32'd100, 32'd7, 32'h0000_000E, 33);
        collect("b2b_divu");
        drive(3'b000, 32'd6, 32'd7, 32'h0000_002A, 2);
        #1;
        chk("b2b_done_cycle_stall", 32'(bus.stall_o), 32'd0);
        step();
        chk("b2b_gap_busy", 32'(bus.busy_o), 32'd0);
        chk("b2b_gap_done", 32'(bus.done_o), 32'd0);
        collect("b2b_mul");
        bus.start_i = 1'b0;
        step();
        chk("b2b_end_busy", 32'(bus.busy_o), 32'd0);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 2 == 1) ? $urandom_range(1, 50) : $urandom;
            run(rop, ra, rb, model(rop, ra, rb), lat_of(rop, ra, rb), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
